i2s_receive: RTL and testbench



---
 rtl/i2s_receive.sv | 66 ++++++
 tb/tb_i2s_receive.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/i2s_receive.sv
// Philips I2S slave receiver: deserialises MSB-first stereo words on sd
// into parallel left/right words, all in the sck domain.
module i2s_receive #(
    parameter int WIDTH = 32
) (
    input  logic             sck,
    input  logic             reset_n,
    input  logic             ws,
    input  logic             sd,
    output logic [WIDTH-1:0] data_left,
    output logic [WIDTH-1:0] data_right
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             ws_r;
    logic             armed;
    logic             ws_edge;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] word;
    logic [CW-1:0]    count;

    assign ws_edge = (ws != ws_r);

    // Current word including this cycle's sample; a saturated count drops it.
    always_comb begin
        word = shift;
        for (int i = 0; i < WIDTH; i++) begin
            if (count == CW'(WIDTH - 1 - i)) begin
                word[i] = sd;
            end
        end
    end

    always_ff @(posedge sck or negedge reset_n) begin
        if (!reset_n) begin
            ws_r       <= 1'b0;
            armed      <= 1'b0;
            shift      <= '0;
            count      <= '0;
            data_left  <= '0;
            data_right <= '0;
        end else begin
            ws_r <= ws;
            if (ws_edge) begin
                // The edge sample is the closing word's last bit.
                if (armed) begin
                    if (!ws_r) begin
                        data_left <= word;
                    end else begin
                        data_right <= word;
                    end
                end
                shift <= '0;
                count <= '0;
                armed <= 1'b1;
            end else begin
                shift <= word;
                if (count != CW'(WIDTH)) begin
                    count <= count + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_receive.sv
// Self-checking bench for i2s_receive: slot-level serial driver with a
// scoreboard queue of expected commits, table vectors and corner sequences.
module tb_i2s_receive;

    logic        sck;
    logic        reset_n;
    logic        ws;
    logic        sd;
    logic [31:0] data_left;
    logic [31:0] data_right;

    i2s_receive #(.WIDTH(32)) dut (
        .sck       (sck),
        .reset_n   (reset_n),
        .ws        (ws),
        .sd        (sd),
        .data_left (data_left),
        .data_right(data_right)
    );

    initial begin
        sck = 1'b0;
        forever #5 sck = ~sck;
    end

    typedef struct {
        logic        w;
        logic [31:0] word;
        int          len;
        logic [31:0] expv;
    } vec_t;

    typedef struct {
        logic        ch;
        logic [31:0] val;
    } sb_t;

    sb_t         q[$];
    vec_t        tbl[10];
    int          checks;
    int          failures;
    logic [31:0] exp_l;
    logic [31:0] exp_r;
    logic        armed_m;
    logic        ws_m;
    logic        have_prev;
    logic        prev_ws;
    logic [31:0] prev_exp;
    logic        pend;

    function automatic logic rnd_bit();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic logic bitv(input logic [31:0] w, input int j);
        if (j < 32) return w[31-j];
        return rnd_bit();
    endfunction

    task automatic cmp(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic check_out(input string tag);
        sb_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.ch) exp_r = e.val;
            else exp_l = e.val;
        end
        cmp($sformatf("%s left", tag), data_left, exp_l);
        cmp($sformatf("%s right", tag), data_right, exp_r);
    endtask

    // One ws slot of len sck; a slot with no ws change continues the
    // previous word, whose extra samples are ignored by the receiver.
    task automatic send_slot(input logic w, input logic [31:0] word,
                             input int len, input logic [31:0] expv,
                             input string tag);
        logic edge_m;
        logic fresh;
        edge_m = (w != ws_m);
        fresh  = edge_m || !have_prev;
        for (int k = 0; k < len; k++) begin
            @(negedge sck);
            if (k == 1 || (k == len - 1 && len > 2)) check_out(tag);
            if (k == 0) begin
                ws = w;
                sd = pend;
                if (edge_m) begin
                    if (armed_m) q.push_back('{ch: prev_ws, val: prev_exp});
                    armed_m = 1'b1;
                end
                ws_m = w;
            end else begin
                sd = fresh ? bitv(word, k - 1) : rnd_bit();
            end
        end
        pend = fresh ? bitv(word, len - 1) : rnd_bit();
        if (fresh) begin
            have_prev = 1'b1;
            prev_ws   = w;
            prev_exp  = expv;
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge sck);
        #2;
        reset_n   = 1'b0;
        ws        = 1'b0;
        sd        = 1'b0;
        exp_l     = '0;
        exp_r     = '0;
        armed_m   = 1'b0;
        ws_m      = 1'b0;
        have_prev = 1'b0;
        pend      = 1'b0;
        q.delete();
        #1;
        cmp($sformatf("%s left", tag), data_left, 32'h0);
        cmp($sformatf("%s right", tag), data_right, 32'h0);
        repeat (2) @(negedge sck);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] r1;
        logic [31:0] r2;
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        ws       = 1'b0;
        sd       = 1'b0;

        tbl[0] = '{1'b1, 32'h1111_2222, 32, 32'h1111_2222};
        tbl[1] = '{1'b0, 32'h8000_0001, 32, 32'h8000_0001};
        tbl[2] = '{1'b1, 32'h7FFF_FFFE, 32, 32'h7FFF_FFFE};
        tbl[3] = '{1'b0, 32'h1234_5678, 40, 32'h1234_5678};
        tbl[4] = '{1'b1, 32'hABCD_0000, 16, 32'hABCD_0000};
        tbl[5] = '{1'b0, 32'hFFFF_FFFF, 32, 32'hFFFF_FFFF};
        tbl[6] = '{1'b1, 32'h0000_0000, 32, 32'h0000_0000};
        tbl[7] = '{1'b0, 32'hC000_0000, 2,  32'hC000_0000};
        tbl[8] = '{1'b1, 32'hA5A5_A5A5, 33, 32'hA5A5_A5A5};
        tbl[9] = '{1'b0, 32'h5A5A_5A5A, 32, 32'h5A5A_5A5A};

        do_reset("reset");

        // Partial left slot with no preceding edge: must not commit.
        send_slot(1'b0, 32'hFFC0_0000, 10, 32'hFFC0_0000, "partial");
        for (int i = 0; i < 10; i++) begin
            send_slot(tbl[i].w, tbl[i].word, tbl[i].len, tbl[i].expv,
                      $sformatf("vec%0d", i));
        end

        // ws held high for 200 sck after a full right word.
        send_slot(1'b1, 32'hDEAD_BEEF, 32, 32'hDEAD_BEEF, "hold_pre");
        send_slot(1'b1, 32'h0, 200, 32'h0, "hold");
        send_slot(1'b0, 32'h2468_ACE0, 32, 32'h2468_ACE0, "hold_post");

        // Reset in the middle of a right word.
        send_slot(1'b1, 32'hFFFF_0000, 10, 32'hFFFF_0000, "mid");
        do_reset("mid_reset");
        send_slot(1'b1, 32'h3C3C_3C3C, 32, 32'h3C3C_3C3C, "rearm");
        send_slot(1'b0, 32'h0F0F_1234, 32, 32'h0F0F_1234, "post_r");
        send_slot(1'b1, 32'h5555_AAAA, 32, 32'h5555_AAAA, "post_l");

        // Continuous random stereo frames.
        do_reset("reset2");
        for (int i = 0; i < 100; i++) begin
            r1 = $urandom();
            r2 = $urandom();
            send_slot(1'b0, r1, 32, r1, $sformatf("rnd%0d_l", i));
            send_slot(1'b1, r2, 32, r2, $sformatf("rnd%0d_r", i));
        end
        send_slot(1'b0, 32'h0, 32, 32'h0, "flush");

        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard: %0d entries left, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
